// File: rtl/bus_master_ctrl.sv
// Bus master controller: queues read/write requests from the control unit in a
// small FIFO and issues them in order, one at a time, on the single-master bus.
// Returns read data and write completion, and aborts transactions that stall
// for too long.
module bus_master_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_mode,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              write_done,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] BUS_addr,
  output logic [DATA_W-1:0] BUS_wdata,
  input  logic [DATA_W-1:0] BUS_rdata,
  output logic              BUS_valid,
  output logic              BUS_mode,
  input  logic              BUS_wready,
  output logic              BUS_rready,
  input  logic              BUS_rvalid
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned ENT_W = 1 + ADDR_W + DATA_W;
  localparam bit          TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_e;

  // FIFO storage and pointers
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Control state
  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;

  // Registered outputs
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              write_done_q, write_done_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              bus_valid_q, bus_valid_d;
  logic              bus_mode_q, bus_mode_d;
  logic              bus_rready_q, bus_rready_d;

  logic              push;
  logic              pop;
  logic              timeout_hit;
  logic [ENT_W-1:0]  head;
  logic              head_mode;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;

  assign push        = req_valid & req_ready_q;
  assign head        = mem_q[rd_ptr_q];
  assign head_mode   = head[ENT_W-1];
  assign head_addr   = head[ENT_W-2 -: ADDR_W];
  assign head_wdata  = head[DATA_W-1:0];
  assign timeout_hit = TO_EN && (timer_q == TMR_W'(TIMEOUT));

  // Transaction FSM: issue the FIFO head, wait for the handshake or the timeout
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    pop           = 1'b0;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    write_done_d  = 1'b0;
    err_d         = 1'b0;
    bus_addr_d    = bus_addr_q;
    bus_wdata_d   = bus_wdata_q;
    bus_valid_d   = bus_valid_q;
    bus_mode_d    = bus_mode_q;
    bus_rready_d  = bus_rready_q;

    case (state_q)
      ST_IDLE: begin
        if (count_q != CNT_W'(0)) begin
          pop          = 1'b1;
          bus_addr_d   = head_addr;
          bus_wdata_d  = head_wdata;
          bus_mode_d   = head_mode;
          bus_valid_d  = 1'b1;
          bus_rready_d = ~head_mode;
          timer_d      = '0;
          state_d      = head_mode ? ST_WR : ST_RD;
        end
      end
      ST_WR: begin
        if (BUS_wready) begin
          bus_valid_d  = 1'b0;
          write_done_d = 1'b1;
          state_d      = ST_IDLE;
        end else if (timeout_hit) begin
          bus_valid_d = 1'b0;
          err_d       = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_RD: begin
        if (BUS_rvalid) begin
          bus_valid_d   = 1'b0;
          bus_rready_d  = 1'b0;
          rdata_d       = BUS_rdata;
          rdata_valid_d = 1'b1;
          state_d       = ST_IDLE;
        end else if (timeout_hit) begin
          bus_valid_d  = 1'b0;
          bus_rready_d = 1'b0;
          err_d        = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        bus_valid_d  = 1'b0;
        bus_rready_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  // FIFO bookkeeping; ready and busy are precomputed so they come straight from flops
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = {req_mode, req_addr, req_wdata};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    req_ready_d = (count_d != CNT_W'(DEPTH));
    busy_d      = (state_d != ST_IDLE) || (count_d != CNT_W'(0));
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q         <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      req_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      write_done_q  <= 1'b0;
      err_q         <= 1'b0;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
      bus_valid_q   <= 1'b0;
      bus_mode_q    <= 1'b0;
      bus_rready_q  <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      timer_q       <= timer_d;
      req_ready_q   <= req_ready_d;
      busy_q        <= busy_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      write_done_q  <= write_done_d;
      err_q         <= err_d;
      bus_addr_q    <= bus_addr_d;
      bus_wdata_q   <= bus_wdata_d;
      bus_valid_q   <= bus_valid_d;
      bus_mode_q    <= bus_mode_d;
      bus_rready_q  <= bus_rready_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign busy        = busy_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign write_done  = write_done_q;
  assign err         = err_q;
  assign BUS_addr    = bus_addr_q;
  assign BUS_wdata   = bus_wdata_q;
  assign BUS_valid   = bus_valid_q;
  assign BUS_mode    = bus_mode_q;
  assign BUS_rready  = bus_rready_q;

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Bench for bus_master_ctrl: random and directed requests, a responding slave
// whose latency is a function of the address, and a transaction-level model of
// the expected bus traffic, completion pulses and status outputs.
module tb_bus_master_ctrl;

  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 8;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_mode;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [DW-1:0] rdata;
  logic          rdata_valid;
  logic          write_done;
  logic          err;
  logic          busy;
  logic [AW-1:0] BUS_addr;
  logic [DW-1:0] BUS_wdata;
  logic [DW-1:0] BUS_rdata;
  logic          BUS_valid;
  logic          BUS_mode;
  logic          BUS_wready;
  logic          BUS_rready;
  logic          BUS_rvalid;

  bus_master_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rdata(rdata), .rdata_valid(rdata_valid), .write_done(write_done),
    .err(err), .busy(busy),
    .BUS_addr(BUS_addr), .BUS_wdata(BUS_wdata), .BUS_rdata(BUS_rdata),
    .BUS_valid(BUS_valid), .BUS_mode(BUS_mode), .BUS_wready(BUS_wready),
    .BUS_rready(BUS_rready), .BUS_rvalid(BUS_rvalid)
  );

  typedef struct packed {
    logic          mode;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave latency (wait cycles before the handshake) derived from the address
  function automatic int unsigned resp_dly(input logic [AW-1:0] a);
    if (a == 32'h10) return 3;
    if (a == 32'h20) return 2;
    return 32'(a[3:0]);
  endfunction

  function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
    if (a == 32'h20) return 32'h12345678;
    return (a * 32'h9E3779B1) ^ 32'hA5A5A5A5;
  endfunction

  logic [103:0] outs_c;
  assign outs_c = {req_ready, rdata, rdata_valid, write_done, err, busy,
                   BUS_addr, BUS_wdata, BUS_valid, BUS_mode, BUS_rready};

  // Driver-to-monitor handoff of accepted requests
  req_t        pend_req;
  int unsigned pend_cnt = 0;
  bit          mon_en   = 1'b0;

  // Model state, owned by the monitor
  req_t          exp_q[$];
  req_t          cur;
  int unsigned   commit_cnt;
  bit            active;
  bit            exp_issue;
  int unsigned   dur;
  int unsigned   wait_cnt;
  logic [DW-1:0] last_rd;
  int unsigned   n_done, n_rv, n_err;

  // Transaction-level monitor plus responding slave, evaluated mid-cycle
  always @(negedge clk) begin
    int unsigned d;
    int unsigned exp_dur;
    logic [2:0]  exp_p;
    bit          hit;
    if (!mon_en) begin
      exp_q.delete();
      commit_cnt = pend_cnt;
      active     = 1'b0;
      exp_issue  = 1'b0;
      last_rd    = '0;
      BUS_wready = 1'b0;
      BUS_rvalid = 1'b0;
      BUS_rdata  = '0;
    end else begin
      n_done += 32'(write_done);
      n_rv   += 32'(rdata_valid);
      n_err  += 32'(err);
      if (pend_cnt != commit_cnt) begin
        exp_q.push_back(pend_req);
        commit_cnt = pend_cnt;
      end
      if (exp_issue) check_eq("issue_latency", 128'(BUS_valid), 128'(1));
      if (BUS_valid && !active) begin
        check_eq("txn_expected", 128'(exp_q.size() != 0), 128'(1));
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          check_eq("bus_mode", 128'(BUS_mode), 128'(cur.mode));
          check_eq("bus_addr", 128'(BUS_addr), 128'(cur.addr));
          if (cur.mode) check_eq("bus_wdata", 128'(BUS_wdata), 128'(cur.wdata));
          active   = 1'b1;
          dur      = 0;
          wait_cnt = 0;
        end
      end
      if (active && BUS_valid) begin
        dur++;
        check_eq("bus_stable", 128'({BUS_mode, BUS_addr}), 128'({cur.mode, cur.addr}));
        if (cur.mode) check_eq("wdata_stable", 128'(BUS_wdata), 128'(cur.wdata));
        check_eq("bus_rready", 128'(BUS_rready), 128'(!cur.mode));
        check_eq("pulse_in_txn", 128'({write_done, rdata_valid, err}), 128'(0));
      end else if (active && !BUS_valid) begin
        d = resp_dly(cur.addr);
        if (d <= TIMEOUT) begin
          exp_dur = d + 1;
          exp_p   = cur.mode ? 3'b100 : 3'b010;
          if (!cur.mode) last_rd = rd_val(cur.addr);
        end else begin
          exp_dur = TIMEOUT + 1;
          exp_p   = 3'b001;
        end
        check_eq("txn_duration", 128'(dur), 128'(exp_dur));
        check_eq("done_pulses", 128'({write_done, rdata_valid, err}), 128'(exp_p));
        check_eq("rready_drop", 128'(BUS_rready), 128'(0));
        active = 1'b0;
      end else begin
        check_eq("idle_pulse", 128'({write_done, rdata_valid, err}), 128'(0));
      end
      check_eq("rdata_hold", 128'(rdata), 128'(last_rd));
      check_eq("busy", 128'(busy), 128'(active || (exp_q.size() != 0)));
      check_eq("req_ready", 128'(req_ready), 128'(exp_q.size() < DEPTH));
      exp_issue = !BUS_valid && (exp_q.size() != 0);
      if (BUS_valid && active) begin
        hit        = (wait_cnt == resp_dly(cur.addr));
        BUS_wready = cur.mode ? hit : 1'($urandom);
        BUS_rvalid = cur.mode ? 1'($urandom) : hit;
        BUS_rdata  = (hit && !cur.mode) ? rd_val(cur.addr) : $urandom;
        wait_cnt++;
      end else begin
        BUS_wready = 1'($urandom);
        BUS_rvalid = 1'($urandom);
        BUS_rdata  = $urandom;
      end
    end
  end

  task automatic push_one(input req_t r);
    int unsigned g = 0;
    @(negedge clk); #1;
    req_valid = 1'b1;
    req_mode  = r.mode;
    req_addr  = r.addr;
    req_wdata = r.wdata;
    while (!req_ready && g < 200) begin
      @(negedge clk); #1;
      g++;
    end
    check_eq("push_accept", 128'(req_ready), 128'(1));
    if (req_ready) begin
      pend_req = r;
      pend_cnt++;
    end
  endtask

  task automatic idle_bus();
    @(negedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned g = 0;
    idle_bus();
    while ((exp_q.size() != 0 || active || busy || pend_cnt != commit_cnt) && g < 400) begin
      @(negedge clk);
      g++;
    end
    check_eq("drain_bound", 128'(g < 400), 128'(1));
    repeat (2) @(negedge clk);
  endtask

  function automatic req_t mk(input logic m, input logic [AW-1:0] a, input logic [DW-1:0] w);
    req_t r;
    r.mode  = m;
    r.addr  = a;
    r.wdata = w;
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d of %0d checks failed", n_fail, n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned d0, r0, e0, k;
    req_t        r;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_mode  = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", 128'(outs_c), 128'(0));
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Single write with latency check
    d0 = n_done; e0 = n_err;
    push_one(mk(1'b1, 32'h10, 32'hDEADBEEF));
    @(negedge clk);
    check_eq("lat_n1_valid", 128'(BUS_valid), 128'(0));
    #1 req_valid = 1'b0;
    @(negedge clk);
    check_eq("lat_n2_valid", 128'(BUS_valid), 128'(1));
    wait_idle();
    check_eq("wr_done_cnt", 128'(n_done - d0), 128'(1));
    check_eq("wr_err_cnt", 128'(n_err - e0), 128'(0));

    // Single read
    r0 = n_rv;
    push_one(mk(1'b0, 32'h20, 32'h0));
    wait_idle();
    check_eq("rd_data", 128'(rdata), 128'(32'h12345678));
    check_eq("rd_valid_cnt", 128'(n_rv - r0), 128'(1));

    // Back-to-back pushes into a stalled bus, twice to wrap the pointers
    for (int rep = 0; rep < 2; rep++) begin
      k = 0;
      for (int c = 0; c < 7; c++) begin
        @(negedge clk); #1;
        r = mk(1'b1, 32'h100 + k * 32'h10 + 32'h5, $urandom);
        req_valid = 1'b1;
        req_mode  = r.mode;
        req_addr  = r.addr;
        req_wdata = r.wdata;
        if (req_ready) begin
          pend_req = r;
          pend_cnt++;
          k++;
        end
      end
      check_eq("fill_accepted", 128'(k), 128'(DEPTH + 1));
      check_eq("fill_ready_low", 128'(req_ready), 128'(0));
      d0 = n_done;
      wait_idle();
      check_eq("fill_done_cnt", 128'(n_done - d0), 128'(k));
    end

    // Timeout on a silent slave, then the queued read completes
    e0 = n_err; r0 = n_rv;
    push_one(mk(1'b0, 32'h3F, 32'h0));
    push_one(mk(1'b0, 32'h44, 32'h0));
    wait_idle();
    check_eq("to_err_cnt", 128'(n_err - e0), 128'(1));
    check_eq("to_rv_cnt", 128'(n_rv - r0), 128'(1));
    check_eq("to_rdata", 128'(rdata), 128'(rd_val(32'h44)));

    // Handshake exactly at the timeout limit
    d0 = n_done; e0 = n_err;
    push_one(mk(1'b1, 32'h58, 32'hCAFEF00D));
    wait_idle();
    check_eq("edge_done_cnt", 128'(n_done - d0), 128'(1));
    check_eq("edge_err_cnt", 128'(n_err - e0), 128'(0));

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        r.mode      = 1'($urandom);
        r.addr      = $urandom;
        r.addr[3:0] = 4'($urandom_range(0, 15));
        r.wdata     = $urandom;
        push_one(r);
      end else begin
        idle_bus();
      end
    end
    wait_idle();
    check_eq("rand_idle_busy", 128'(busy), 128'(0));

    // Reset in the middle of a read with three requests queued
    push_one(mk(1'b0, 32'h6F, 32'h0));
    push_one(mk(1'b1, 32'h72, 32'h11111111));
    push_one(mk(1'b1, 32'h82, 32'h22222222));
    push_one(mk(1'b1, 32'h92, 32'h33333333));
    idle_bus();
    check_eq("rst_setup", 128'({active, 32'(exp_q.size())}), 128'({1'b1, 32'd3}));
    d0 = n_done; r0 = n_rv; e0 = n_err;
    @(negedge clk); #3;
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    check_eq("rst_async_outs", 128'(outs_c), 128'(0));
    repeat (2) @(negedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("post_rst_pulses", 128'({n_done - d0, n_rv - r0, n_err - e0}), 128'(0));
    check_eq("post_rst_outs", 128'(outs_c), 128'({1'b1, 103'd0}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
